// File: rtl/shift_sequencer_if.sv
// Command/result channel bundle for shift_sequencer.
//
// Purpose: groups the two valid/ready handshakes that connect a command
// master (CPU or bus FSM) to the shift sequencer.
//
// Signals:
//   cmd_valid  master -> seq  command offered
//   cmd_ready  seq -> master  sequencer idle, command will be taken
//   cmd_dir    master -> seq  1 = shift right (toward bit 0), 0 = shift left
//   cmd_count  master -> seq  number of shift steps (clamped to WIDTH)
//   cmd_data   master -> seq  initial register value
//   res_valid  seq -> master  final register contents available
//   res_ready  master -> seq  result consumed
//   res_data   seq -> master  final register contents
interface shift_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] cmd_data;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;

  modport master (
    output cmd_valid, cmd_dir, cmd_count, cmd_data, res_ready,
    input  cmd_ready, res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_count, cmd_data, res_ready,
    output cmd_ready, res_valid, res_data
  );
endinterface

// File: rtl/shift_sequencer.sv
// Command-driven sequencer for a bidirectional shift register.
//
// Purpose: accepts a load/shift command over bus (cmd channel), loads the
// shift register, performs one shift per clock for the requested number of
// steps while streaming shifted-out bits on ser_out and filling from ser_in,
// then presents the final register contents on the result channel.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous, active-low reset
//   bus        shift_sequencer_if.slave: cmd_* and res_* handshakes
//   ser_in     fill bit, sampled on each shift edge
//   ser_out    bit shifted out on the previous shift edge
//   ser_valid  ser_out carries a valid bit this cycle
//   busy       high whenever the sequencer is not idle
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_sequencer_if.slave      bus,
  input  logic                  ser_in,
  output logic                  ser_out,
  output logic                  ser_valid,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic             dir_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] count_clamped;

  // Requests longer than the register collapse to a full-width shift.
  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
    if (c > CNT_W'(WIDTH))
      return CNT_W'(WIDTH);
    else
      return c;
  endfunction

  assign count_clamped = clamp_count(bus.cmd_count);

  // Handshake outputs depend on the state register only, so there is no
  // combinational path from cmd_valid/res_ready back to the master.
  assign bus.cmd_ready = (state == IDLE);
  assign bus.res_valid = (state == DONE);
  assign bus.res_data  = sreg;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sreg      <= '0;
      dir_q     <= 1'b0;
      cnt       <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
    end else begin
      // ser_valid is a one-cycle strobe per shift edge; ser_out holds.
      ser_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            sreg  <= bus.cmd_data;
            dir_q <= bus.cmd_dir;
            cnt   <= count_clamped;
            state <= (count_clamped != '0) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          if (dir_q) begin
            sreg    <= {ser_in, sreg[WIDTH-1:1]};
            ser_out <= sreg[0];
          end else begin
            sreg    <= {sreg[WIDTH-2:0], ser_in};
            ser_out <= sreg[WIDTH-1];
          end
          ser_valid <= 1'b1;
          cnt       <= cnt - 1'b1;
          // Last step: the final ser_valid cycle overlaps the first DONE cycle.
          if (cnt == CNT_W'(1))
            state <= DONE;
        end
        DONE: begin
          if (bus.res_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  localparam int WIDTH = 16;
  localparam int CNT_W = 5;

  logic clk;
  logic rst;
  logic ser_in;
  logic ser_out;
  logic ser_valid;
  logic busy;

  int total;
  int bad;

  shift_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .ser_in    (ser_in),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a command and wait (bounded) for the accept edge. Returns at
  // accept edge + 1 time unit with cmd_valid dropped.
  task automatic send_cmd(input logic dir, input logic [CNT_W-1:0] count,
                          input logic [WIDTH-1:0] data, output bit ok);
    bit taken;
    taken         = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = dir;
    bus.cmd_count = count;
    bus.cmd_data  = data;
    for (int i = 0; i < 40 && !taken; i++) begin
      if (bus.cmd_ready) taken = 1'b1;
      tick();
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.cmd_count = '0;
    bus.cmd_dir   = ~dir;
    ok = taken;
  endtask

  task automatic test_reset();
    total++;
    if (bus.cmd_ready !== 1'b1) begin
      bad++; $display("FAIL reset_cmd_ready actual=%b required=1", bus.cmd_ready);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy actual=%b required=0", busy);
    end
    total++;
    if (bus.res_valid !== 1'b0 || ser_valid !== 1'b0 || ser_out !== 1'b0) begin
      bad++; $display("FAIL reset_outputs actual res_valid=%b ser_valid=%b ser_out=%b required=0,0,0",
                      bus.res_valid, ser_valid, ser_out);
    end
    total++;
    if (bus.res_data !== 16'h0000) begin
      bad++; $display("FAIL reset_res_data actual=%h required=0000", bus.res_data);
    end
  endtask

  task automatic test_right_shift();
    bit ok;
    logic exp_bits [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    ser_in = 1'b1;
    send_cmd(1'b1, 5'd4, 16'hA5F0, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL right_accept actual=timeout required=accepted");
    end
    total++;
    if (busy !== 1'b1 || bus.cmd_ready !== 1'b0 || ser_valid !== 1'b0) begin
      bad++; $display("FAIL right_after_accept actual busy=%b cmd_ready=%b ser_valid=%b required=1,0,0",
                      busy, bus.cmd_ready, ser_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (ser_valid !== 1'b1 || ser_out !== exp_bits[i]) begin
        bad++; $display("FAIL right_bit%0d actual valid=%b out=%b required valid=1 out=%b",
                        i, ser_valid, ser_out, exp_bits[i]);
      end
      total++;
      if (bus.res_valid !== (i == 3)) begin
        bad++; $display("FAIL right_res_valid_step%0d actual=%b required=%b", i, bus.res_valid, (i == 3));
      end
    end
    total++;
    if (bus.res_data !== 16'hFA5F) begin
      bad++; $display("FAIL right_res_data actual=%h required=FA5F", bus.res_data);
    end
    tick();
    total++;
    if (ser_valid !== 1'b0 || bus.res_valid !== 1'b1 || bus.res_data !== 16'hFA5F) begin
      bad++; $display("FAIL right_hold actual ser_valid=%b res_valid=%b res_data=%h required 0,1,FA5F",
                      ser_valid, bus.res_valid, bus.res_data);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    total++;
    if (bus.cmd_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
      bad++; $display("FAIL right_consume actual cmd_ready=%b res_valid=%b required 1,0",
                      bus.cmd_ready, bus.res_valid);
    end
  endtask

  task automatic test_left_shift();
    bit ok;
    logic exp_bits [3] = '{1'b1, 1'b0, 1'b0};
    ser_in = 1'b0;
    send_cmd(1'b0, 5'd3, 16'h8001, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL left_accept actual=timeout required=accepted");
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (ser_valid !== 1'b1 || ser_out !== exp_bits[i]) begin
        bad++; $display("FAIL left_bit%0d actual valid=%b out=%b required valid=1 out=%b",
                        i, ser_valid, ser_out, exp_bits[i]);
      end
    end
    total++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 16'h0008) begin
      bad++; $display("FAIL left_result actual valid=%b data=%h required valid=1 data=0008",
                      bus.res_valid, bus.res_data);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_zero_count();
    bit ok;
    ser_in = 1'b1;
    send_cmd(1'b1, 5'd0, 16'h1234, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL zero_accept actual=timeout required=accepted");
    end
    total++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 16'h1234 || ser_valid !== 1'b0) begin
      bad++; $display("FAIL zero_result actual valid=%b data=%h ser_valid=%b required 1,1234,0",
                      bus.res_valid, bus.res_data, ser_valid);
    end
    tick();
    total++;
    if (ser_valid !== 1'b0 || bus.res_data !== 16'h1234) begin
      bad++; $display("FAIL zero_hold actual ser_valid=%b data=%h required 0,1234", ser_valid, bus.res_data);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_clamp();
    bit ok;
    int nvalid;
    int nbad_bits;
    nvalid    = 0;
    nbad_bits = 0;
    ser_in = 1'b0;
    send_cmd(1'b1, 5'd31, 16'hFFFF, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL clamp_accept actual=timeout required=accepted");
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ser_valid === 1'b1) begin
        nvalid++;
        if (ser_out !== 1'b1) nbad_bits++;
      end
      if (i == 14) begin
        total++;
        if (bus.res_valid !== 1'b0) begin
          bad++; $display("FAIL clamp_early_res actual=%b required=0 at step 15", bus.res_valid);
        end
      end
      if (i == 15) begin
        total++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 16'h0000) begin
          bad++; $display("FAIL clamp_result actual valid=%b data=%h required 1,0000",
                          bus.res_valid, bus.res_data);
        end
      end
    end
    total++;
    if (nvalid != 16 || nbad_bits != 0) begin
      bad++; $display("FAIL clamp_stream actual valid_cycles=%0d wrong_bits=%0d required 16,0",
                      nvalid, nbad_bits);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    bit seen;
    seen   = 1'b0;
    ser_in = 1'b1;
    send_cmd(1'b0, 5'd2, 16'h0F0F, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL bp_accept actual=timeout required=accepted");
    end
    for (int i = 0; i < 10 && !seen; i++) begin
      if (bus.res_valid === 1'b1) seen = 1'b1;
      else tick();
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL bp_res_wait actual=timeout required=res_valid");
    end
    // New command offered while the result is stalled.
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = 1'b1;
    bus.cmd_count = 5'd0;
    bus.cmd_data  = 16'h5555;
    bus.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== 16'h3C3F || bus.cmd_ready !== 1'b0) begin
        bad++; $display("FAIL bp_stall%0d actual valid=%b data=%h cmd_ready=%b required 1,3C3F,0",
                        i, bus.res_valid, bus.res_data, bus.cmd_ready);
      end
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    total++;
    if (bus.cmd_ready !== 1'b1 || busy !== 1'b0 || bus.res_valid !== 1'b0) begin
      bad++; $display("FAIL bp_release actual cmd_ready=%b busy=%b res_valid=%b required 1,0,0",
                      bus.cmd_ready, busy, bus.res_valid);
    end
    tick();
    bus.cmd_valid = 1'b0;
    total++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 16'h5555) begin
      bad++; $display("FAIL bp_next_cmd actual valid=%b data=%h required 1,5555",
                      bus.res_valid, bus.res_data);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    bit ok;
    bit leak;
    leak   = 1'b0;
    ser_in = 1'b0;
    send_cmd(1'b1, 5'd8, 16'hFFFF, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL rstmid_accept actual=timeout required=accepted");
    end
    tick();
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (ser_valid !== 1'b0 || bus.res_valid !== 1'b0 || busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      bad++; $display("FAIL rstmid_abort actual ser_valid=%b res_valid=%b busy=%b cmd_ready=%b required 0,0,0,1",
                      ser_valid, bus.res_valid, busy, bus.cmd_ready);
    end
    tick();
    tick();
    #2;
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.res_valid !== 1'b0 || ser_valid !== 1'b0 || busy !== 1'b0) leak = 1'b1;
    end
    total++;
    if (leak) begin
      bad++; $display("FAIL rstmid_after_release actual=activity required=idle");
    end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b0;
    ser_in        = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_dir   = 1'b0;
    bus.cmd_count = '0;
    bus.cmd_data  = '0;
    bus.res_ready = 1'b0;
    #1;
    test_reset();
    tick();
    tick();
    #2;
    rst = 1'b1;
    tick();
    test_reset_mid_shift();
    test_right_shift();
    test_left_shift();
    test_zero_count();
    test_clamp();
    test_backpressure();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Command-driven controller that sequences a 16-bit bidirectional shift datapath. Accepts a load/shift command (data, direction, step count) over a valid/ready handshake and loads the internal shift register. It shifts one position per clock for the requested number of steps, streaming the shifted-out bits serially and filling from a serial input. It then returns the final register contents over a valid/ready result handshake. It sits between a command master (CPU/bus FSM) and a serial link.

Parameters:
WIDTH, 16, shift register width in bits
CNT_W, 5, width of step-count field; must satisfy 2**CNT_W > WIDTH

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a rising edge
cmd_dir  input  1  1 = shift right (toward bit 0), 0 = shift left
cmd_count  input  CNT_W  number of shift steps; values > WIDTH clamp to WIDTH
cmd_data  input  WIDTH  initial register value
ser_in  input  1  fill bit, sampled on each shift edge
ser_out  output  1  bit shifted out on the previous shift edge
ser_valid  output  1  ser_out carries a valid bit this cycle
res_valid  output  1  result available
res_ready  input  1  result consumed when res_valid && res_ready at a rising edge
res_data  output  WIDTH  final register contents, meaningful only while res_valid
busy  output  1  high whenever state != IDLE

Behaviour:
- States: IDLE, SHIFT, DONE. Internal: sreg[WIDTH-1:0], dir_q, cnt[CNT_W-1:0].
- Reset (rst low, async): state=IDLE, sreg=0, cnt=0, dir_q=0, ser_out=0, ser_valid=0, res_valid=0, busy=0. cmd_ready=1 during and after reset. Reset mid-operation aborts immediately; no result is produced.
- cmd_ready = (state==IDLE), combinational from state only. busy = (state!=IDLE). res_valid = (state==DONE). res_data = sreg.
- IDLE: on accept edge E0: sreg<=cmd_data, dir_q<=cmd_dir, cnt<=min(cmd_count, WIDTH). Next state SHIFT if clamped count>0, else DONE.
- SHIFT: each edge performs one step. Right: sreg<={ser_in, sreg[WIDTH-1:1]}, ser_out<=sreg[0]. Left: sreg<={sreg[WIDTH-2:0], ser_in}, ser_out<=sreg[WIDTH-1]. ser_valid<=1, cnt<=cnt-1. On the edge where cnt==1, next state is DONE.
- Outside a shift edge, ser_valid<=0 and ser_out holds its last value.
- Timing for N steps: shift edges E1..EN. ser_valid is high for exactly N consecutive cycles (after E1..EN). res_valid rises after EN. The last ser_valid cycle coincides with the first DONE cycle.
- N=0: DONE after E0, res_data=cmd_data, ser_valid never asserted.
- DONE: sreg, res_valid and res_data hold until res_ready is sampled high. Then next state is IDLE and cmd_ready=1 the following cycle.
- cmd_valid while busy is ignored; the master holds its command. res_ready outside DONE is ignored.
- A command offered in the same cycle as the result is consumed is not accepted (cmd_ready is low in DONE). It is accepted at the next edge at the earliest.
- Minimum command-to-command period is N+2 cycles.
- cmd_dir, cmd_count and cmd_data are sampled only at the accept edge. Changes during SHIFT have no effect.

Test Plan:
1. Reset mid-shift: accept 0xFFFF/count 8, pull rst low after 3 shift edges -> immediately state IDLE, ser_valid=0, res_valid=0, busy=0, cmd_ready=1. No res_valid after release.
2. Right shift: cmd_data=0xA5F0, dir=1, count=4, ser_in=1 -> ser_out stream 0,0,0,0 with ser_valid high 4 cycles. res_valid rises after the 4th shift edge with res_data=0xFA5F.
3. Left shift: cmd_data=0x8001, dir=0, count=3, ser_in=0 -> ser_out 1,0,0, then res_data=0x0008.
4. Zero count: cmd_data=0x1234, count=0 -> res_valid the cycle after accept, res_data=0x1234, ser_valid stays 0.
5. Clamp: cmd_data=0xFFFF, count=31, ser_in=0, dir=1 -> exactly 16 ser_valid cycles all ser_out=1, res_data=0x0000.
6. Backpressure: hold res_ready low 5 cycles in DONE while driving cmd_valid -> res_valid/res_data stable, cmd_ready=0, no command accepted. Raise res_ready -> IDLE next cycle, command accepted one cycle later.
